// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the universal shift register: turns one LOAD/shift
// command into the S/X/r_in/l_in drive it needs, then reports Q with a pulse.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       S,
  output logic [WIDTH-1:0] X,
  output logic             r_in,
  output logic             l_in,
  input  logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             err
);

  // state    | meaning
  // ST_IDLE  | waiting for a command, cmd_ready high
  // ST_LOAD  | one cycle of parallel load (S=11)
  // ST_SHIFT | shifting, cnt_q cycles left including this one
  // ST_DONE  | response cycle, rsp_valid high, Q forwarded
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_SHR   = 3'b001;
  localparam logic [2:0] OP_SHRA  = 3'b010;
  localparam logic [2:0] OP_ROR   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_SHL1  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               err_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LOAD;
      cnt_q      <= '0;
      x_q        <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            cnt_q <= cmd_amt;
            if (cmd_op == OP_LOAD) begin
              x_q     <= cmd_data;
              state_q <= ST_LOAD;
            end else if (cmd_op == OP_RSVD || cmd_amt == '0) begin
              err_q   <= (cmd_op == OP_RSVD);
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_LOAD: begin
          err_q   <= 1'b0;
          state_q <= ST_DONE;
        end
        ST_SHIFT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            err_q   <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          rsp_data_q <= Q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Serial inputs follow live Q so rotates/arith shifts see each intermediate value.
  always_comb begin
    S    = 2'b00;
    r_in = 1'b0;
    l_in = 1'b0;
    case (state_q)
      ST_LOAD: S = 2'b11;
      ST_SHIFT: begin
        case (op_q)
          OP_SHR:  S = 2'b01;
          OP_SHRA: begin S = 2'b01; r_in = Q[WIDTH-1]; end
          OP_ROR:  begin S = 2'b01; r_in = Q[0];       end
          OP_SHL:  S = 2'b10;
          OP_ROL:  begin S = 2'b10; l_in = Q[WIDTH-1]; end
          OP_SHL1: begin S = 2'b10; l_in = 1'b1;       end
          default: S = 2'b00;
        endcase
      end
      default: S = 2'b00;
    endcase
  end

  // Q is final once DONE is reached, so it is forwarded that cycle and captured to hold afterwards.
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_data  = (state_q == ST_DONE) ? Q : rsp_data_q;
  assign err       = err_q;
  assign X         = x_q;

endmodule
